// File: rtl/uart_mmio_peripheral.sv
// Memory-mapped 8N1 UART (TXD/RXD/CON at 0x4000_0018..0x4000_0020) with independent TX/RX FSMs.
// Optional registered interrupt output when UART_IRQ_EN is defined.
module uart_mmio_peripheral #(
    parameter int unsigned BAUD_DIV = 10416
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_wr,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx
`ifdef UART_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [31:0] AddrTxd = 32'h4000_0018;
    localparam logic [31:0] AddrRxd = 32'h4000_001C;
    localparam logic [31:0] AddrCon = 32'h4000_0020;

    localparam int unsigned     CntW     = $clog2(BAUD_DIV);
    localparam logic [CntW-1:0] BitLast  = CntW'(BAUD_DIV - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            tx_state_q, tx_state_d;
    state_e            rx_state_q, rx_state_d;
    logic [7:0]        txd_q, txd_d;
    logic [7:0]        rxd_q, rxd_d;
    logic              tx_en_q, tx_en_d;
    logic              rx_en_q, rx_en_d;
    logic              tx_done_q, tx_done_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_ack_q, tx_ack_d;
    logic              tx_line_q, tx_line_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic [CntW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [CntW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    // [0],[1] form the synchronizer; [2] is the previous synchronized sample for edge detect.
    logic [2:0]        rx_sync_q, rx_sync_d;

    logic wr_txd, wr_con, rx_line, rx_prev;
    logic unused_wdata;

    assign wr_txd       = mem_wr && (addr == AddrTxd);
    assign wr_con       = mem_wr && (addr == AddrCon);
    assign rx_line      = rx_sync_q[1];
    assign rx_prev      = rx_sync_q[2];
    assign unused_wdata = ^wdata[31:8];
    assign uart_tx      = tx_line_q;

    always_comb begin
        txd_d      = txd_q;
        rxd_d      = rxd_q;
        tx_en_d    = tx_en_q;
        rx_en_d    = rx_en_q;
        tx_done_d  = tx_done_q;
        rx_valid_d = rx_valid_q;
        tx_ack_d   = tx_ack_q;
        tx_line_d  = tx_line_q;
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sync_d  = {rx_sync_q[1:0], uart_rx};

        if (wr_txd) begin
            txd_d = wdata[7:0];
        end

        case (tx_state_q)
            StIdle: begin
                if (wr_con && wdata[0] && !tx_en_q) begin
                    tx_state_d = StStart;
                    tx_shift_d = txd_q;
                    tx_cnt_d   = '0;
                    tx_line_d  = 1'b0;
                end
            end
            StStart: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = StData;
                    tx_line_d  = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = StStop;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_line_d  = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (tx_cnt_q == BitLast) begin
                    tx_state_d = StIdle;
                    tx_done_d  = 1'b1;
                    tx_ack_d   = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = StIdle;
        endcase

        case (rx_state_q)
            StIdle: begin
                if (rx_prev && !rx_line) begin
                    rx_state_d = StStart;
                    rx_cnt_d   = '0;
                end
            end
            StStart: begin
                // Half-bit recheck rejects short low glitches.
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_line ? StIdle : StData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_line, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = StStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_state_d = StIdle;
                    if (rx_line && rx_en_q) begin
                        rxd_d      = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = StIdle;
        endcase

        // Applied last so a clearing CON write overrides a same-cycle hardware set.
        if (wr_con) begin
            tx_en_d = wdata[0];
            rx_en_d = wdata[1];
            if (!wdata[0]) begin
                tx_done_d = 1'b0;
                tx_ack_d  = 1'b0;
            end
            if (!wdata[1]) begin
                rx_valid_d = 1'b0;
            end
        end
    end

`ifdef UART_IRQ_EN
    logic irq_q, irq_d;
    assign irq_d = (rx_valid_d & rx_en_d) | (tx_done_d & tx_en_d);
    assign irq   = irq_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            txd_q      <= '0;
            rxd_q      <= '0;
            tx_en_q    <= 1'b0;
            rx_en_q    <= 1'b0;
            tx_done_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_ack_q   <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_state_q <= StIdle;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            rx_state_q <= StIdle;
            rx_shift_q <= '0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sync_q  <= 3'b111;
`ifdef UART_IRQ_EN
            irq_q      <= 1'b0;
`endif
        end else begin
            txd_q      <= txd_d;
            rxd_q      <= rxd_d;
            tx_en_q    <= tx_en_d;
            rx_en_q    <= rx_en_d;
            tx_done_q  <= tx_done_d;
            rx_valid_q <= rx_valid_d;
            tx_ack_q   <= tx_ack_d;
            tx_line_q  <= tx_line_d;
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sync_q  <= rx_sync_d;
`ifdef UART_IRQ_EN
            irq_q      <= irq_d;
`endif
        end
    end

    always_comb begin
        rdata = '0;
        if (addr == AddrTxd) begin
            rdata = {24'b0, txd_q};
        end else if (addr == AddrRxd) begin
            rdata = {24'b0, rxd_q};
        end else if (addr == AddrCon) begin
            rdata = {27'b0, tx_ack_q, rx_valid_q, tx_done_q, rx_en_q, tx_en_q};
        end
    end

endmodule

// File: tb/tb_uart_mmio_peripheral.sv
// Self-checking bench for uart_mmio_peripheral with BAUD_DIV=4: register table, directed
// TX/RX/reset sequences, and randomized concurrent TX/RX frames against a frame-level model.
module tb_uart_mmio_peripheral;

    localparam int unsigned B = 4;
    localparam logic [31:0] AddrTxd = 32'h4000_0018;
    localparam logic [31:0] AddrRxd = 32'h4000_001C;
    localparam logic [31:0] AddrCon = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_wr;
    logic [31:0] rdata;
    logic        uart_rx;
    logic        uart_tx;

    int vectors = 0;
    int miscompares = 0;

    uart_mmio_peripheral #(.BAUD_DIV(B)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .mem_wr (mem_wr),
        .rdata  (rdata),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [0:14];

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endfunction

    // Expected line level k cycles after the start-bit edge, from the 8N1 frame layout.
    function automatic logic exp_tx(input logic [7:0] b, input int k);
        logic [9:0] fr;
        int idx;
        fr  = {1'b1, b, 1'b0};
        idx = k / int'(B);
        return (idx > 9) ? 1'b1 : fr[idx];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        wdata  = d;
        mem_wr = 1'b1;
        tick();
        mem_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        for (int i = 0; i < 10; i++) begin
            uart_rx = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
            repeat (B) tick();
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]  m_rxd;
        logic        m_valid;
        logic        rx_en;
        logic        stop;
        logic [7:0]  txb;
        logic [7:0]  rxb;
        logic [31:0] w;
        int          lows;

        reset   = 1'b0;
        addr    = '0;
        wdata   = '0;
        mem_wr  = 1'b0;
        uart_rx = 1'b1;

        tbl[0]  = '{1'b0, AddrTxd, 32'h0};
        tbl[1]  = '{1'b0, AddrRxd, 32'h0};
        tbl[2]  = '{1'b0, AddrCon, 32'h0};
        tbl[3]  = '{1'b1, AddrTxd, 32'h1234_56A5};
        tbl[4]  = '{1'b0, AddrTxd, 32'h0000_00A5};
        tbl[5]  = '{1'b1, AddrCon, 32'h0000_001C};
        tbl[6]  = '{1'b0, AddrCon, 32'h0};
        tbl[7]  = '{1'b1, AddrCon, 32'h0000_0002};
        tbl[8]  = '{1'b0, AddrCon, 32'h0000_0002};
        tbl[9]  = '{1'b1, AddrRxd, 32'h0000_00FF};
        tbl[10] = '{1'b0, AddrRxd, 32'h0};
        tbl[11] = '{1'b0, 32'h4000_0024, 32'h0};
        tbl[12] = '{1'b0, 32'h0000_0018, 32'h0};
        tbl[13] = '{1'b1, AddrCon, 32'h0};
        tbl[14] = '{1'b0, AddrCon, 32'h0};

        repeat (2) tick();
        check("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].wr) begin
                bus_write(tbl[i].addr, tbl[i].data);
            end else begin
                read_check($sformatf("table_%0d", i), tbl[i].addr, tbl[i].data);
            end
        end
        check("table_no_frame", {31'b0, uart_tx}, 32'h1);

        // Basic frame 0x55.
        bus_write(AddrTxd, 32'h55);
        bus_write(AddrCon, 32'h1);
        for (int k = 0; k <= 10 * int'(B); k++) begin
            check($sformatf("tx55_bit_k%0d", k), {31'b0, uart_tx}, {31'b0, exp_tx(8'h55, k)});
            if (k == 10 * int'(B) - 1) read_check("tx55_con_busy", AddrCon, 32'h01);
            if (k == 10 * int'(B)) read_check("tx55_con_done", AddrCon, 32'h15);
            if (k < 10 * int'(B)) tick();
        end
        bus_write(AddrCon, 32'h0);
        read_check("tx55_con_cleared", AddrCon, 32'h0);

        // TXD rewrite, TX_EN clear and re-set mid-frame must not disturb or restart it.
        bus_write(AddrTxd, 32'h96);
        bus_write(AddrCon, 32'h1);
        for (int k = 0; k <= 10 * int'(B); k++) begin
            check($sformatf("tx96_bit_k%0d", k), {31'b0, uart_tx}, {31'b0, exp_tx(8'h96, k)});
            if (k == 6) bus_write(AddrTxd, 32'hFF);
            else if (k == 10) bus_write(AddrCon, 32'h0);
            else if (k == 14) bus_write(AddrCon, 32'h1);
            else if (k < 10 * int'(B)) tick();
        end
        read_check("tx96_con_done", AddrCon, 32'h15);
        lows = 0;
        for (int k = 0; k < 3 * int'(B); k++) begin
            tick();
            if (uart_tx !== 1'b1) lows++;
        end
        check("tx96_no_restart", lows, 0);
        read_check("tx96_txd", AddrTxd, 32'hFF);
        bus_write(AddrCon, 32'h0);

        // RX directed sequences.
        bus_write(AddrCon, 32'h2);
        send_rx(8'hA3, 1'b1);
        repeat (4) tick();
        read_check("rxa3_con", AddrCon, 32'h0A);
        read_check("rxa3_rxd", AddrRxd, 32'hA3);
        bus_write(AddrCon, 32'h0);
        read_check("rxa3_con_cleared", AddrCon, 32'h0);

        send_rx(8'h3C, 1'b1);
        repeat (4) tick();
        read_check("rx_disabled_con", AddrCon, 32'h0);
        read_check("rx_disabled_rxd", AddrRxd, 32'hA3);

        bus_write(AddrCon, 32'h2);
        send_rx(8'h3C, 1'b0);
        repeat (4) tick();
        read_check("rx_framing_con", AddrCon, 32'h02);
        read_check("rx_framing_rxd", AddrRxd, 32'hA3);

        uart_rx = 1'b0;
        tick();
        uart_rx = 1'b1;
        repeat (50) tick();
        read_check("rx_glitch_con", AddrCon, 32'h02);
        read_check("rx_glitch_rxd", AddrRxd, 32'hA3);

        // Randomized concurrent TX/RX frames checked against a frame-level register model.
        m_rxd   = 8'hA3;
        m_valid = 1'b0;
        for (int it = 0; it < 20; it++) begin
            rx_en = 1'($urandom_range(0, 1));
            stop  = ($urandom_range(0, 3) != 0);
            rxb   = 8'($urandom);
            w     = $urandom;
            txb   = w[7:0];
            bus_write(AddrCon, {30'b0, rx_en, 1'b0});
            if (!rx_en) m_valid = 1'b0;
            bus_write(AddrTxd, w);
            bus_write(AddrCon, {30'b0, rx_en, 1'b1});
            fork
                begin
                    for (int k = 0; k <= 10 * int'(B); k++) begin
                        check($sformatf("rnd%0d_tx_k%0d", it, k), {31'b0, uart_tx},
                              {31'b0, exp_tx(txb, k)});
                        if (k < 10 * int'(B)) tick();
                    end
                end
                begin
                    send_rx(rxb, stop);
                    repeat (4) tick();
                end
            join
            if (rx_en && stop) begin
                m_valid = 1'b1;
                m_rxd   = rxb;
            end
            read_check($sformatf("rnd%0d_con", it), AddrCon,
                       {27'b0, 1'b1, m_valid, 1'b1, rx_en, 1'b1});
            read_check($sformatf("rnd%0d_rxd", it), AddrRxd, {24'b0, m_rxd});
            read_check($sformatf("rnd%0d_txd", it), AddrTxd, {24'b0, txb});
        end

        // Reset mid-frame aborts transmission.
        bus_write(AddrCon, 32'h0);
        bus_write(AddrTxd, 32'h00);
        bus_write(AddrCon, 32'h1);
        for (int k = 0; k < 15; k++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midreset_uart_tx", {31'b0, uart_tx}, 32'h1);
        read_check("midreset_con", AddrCon, 32'h0);
        read_check("midreset_txd", AddrTxd, 32'h0);
        read_check("midreset_rxd", AddrRxd, 32'h0);
        lows = 0;
        for (int k = 0; k < 11 * int'(B); k++) begin
            tick();
            if (uart_tx !== 1'b1) lows++;
        end
        check("midreset_no_bits", lows, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
